// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
//
// Instruction-memory responder for the fetch stage. A fetch request is taken
// over a valid/ready request channel. The matching 32-bit instruction comes
// back over a valid/ready response channel a fixed LATENCY cycles later. A
// branch-redirect flush drops any outstanding request. A word-wide load port
// preloads program contents while the responder is idle.
//
// Parameters
//   DEPTH    memory size in 32-bit words (power of two)
//   LATENCY  cycles from request acceptance to response valid (1..15)
//
// Ports
//   i_clk        clock; all state updates on the rising edge
//   i_rst        synchronous active-high reset
//   i_req_valid  fetch request present
//   i_req_addr   byte address of the instruction (PC)
//   o_req_ready  request accepted when high together with i_req_valid (comb.)
//   o_rsp_valid  response data/err valid (registered)
//   o_rsp_data   instruction word (registered)
//   o_rsp_err    misaligned or out-of-range request (registered)
//   i_rsp_ready  consumer takes the response this cycle
//   i_flush      drop any outstanding request
//   i_ld_en      load-port write strobe
//   i_ld_addr    load word index
//   i_ld_data    load data
// ---------------------------------------------------------------------------
module imem_responder #(
  parameter int unsigned DEPTH   = 2048,
  parameter int unsigned LATENCY = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req_valid,
  input  logic [31:0]              i_req_addr,
  output logic                     o_req_ready,
  output logic                     o_rsp_valid,
  output logic [31:0]              o_rsp_data,
  output logic                     o_rsp_err,
  input  logic                     i_rsp_ready,
  input  logic                     i_flush,
  input  logic                     i_ld_en,
  input  logic [$clog2(DEPTH)-1:0] i_ld_addr,
  input  logic [31:0]              i_ld_data
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);
  localparam logic [31:0] Nop     = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic        r_rsp_err;

  // Instruction storage; not touched by reset.
  logic [31:0] r_mem [DEPTH];

  logic        w_accept;
  logic        w_ld_we;
  logic [31:0] w_rd_addr;
  logic [AW-1:0] w_rd_idx;
  logic        w_rd_bad;
  logic [31:0] w_rd_word;

  // Ready is the only combinational output. Flush and load both block
  // acceptance in the cycle they are asserted.
  assign o_req_ready = !i_flush && !i_ld_en &&
                       ((r_state == StIdle) || ((r_state == StResp) && i_rsp_ready));

  assign w_accept = i_req_valid && o_req_ready;

  // Loads are honoured only while idle and not flushing.
  assign w_ld_we = i_ld_en && !i_flush && (r_state == StIdle);

  // While waiting, the lookup uses the latched address. Otherwise the lookup
  // serves the LATENCY=1 case, where the response is loaded on the accept edge.
  assign w_rd_addr = (r_state == StWait) ? r_addr : i_req_addr;
  assign w_rd_idx  = w_rd_addr[AW+1:2];

  // Out of range means any word-index bit above the memory's index width is set.
  assign w_rd_bad  = (w_rd_addr[1:0] != 2'b00) || (|w_rd_addr[31:AW+2]);
  assign w_rd_word = w_rd_bad ? Nop : r_mem[w_rd_idx];

  always_ff @(posedge i_clk) begin
    if (w_ld_we) begin
      r_mem[i_ld_addr] <= i_ld_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_cnt       <= 4'd0;
      r_addr      <= 32'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else if (w_accept) begin
      // Accept happens from IDLE, or from RESP when the response handshake
      // completes in the same cycle.
      r_addr <= i_req_addr;
      if (LATENCY == 1) begin
        r_state     <= StResp;
        r_cnt       <= 4'd0;
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= w_rd_word;
        r_rsp_err   <= w_rd_bad;
      end else begin
        r_state     <= StWait;
        r_cnt       <= CntInit;
        r_rsp_valid <= 1'b0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          r_rsp_valid <= 1'b0;
        end
        StWait: begin
          if (i_flush) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
          end else if (r_cnt == 4'd1) begin
            r_state     <= StResp;
            r_cnt       <= 4'd0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rd_word;
            r_rsp_err   <= w_rd_bad;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StResp: begin
          // Flush beats the handshake; both leave without a new request.
          if (i_flush || i_rsp_ready) begin
            r_state     <= StIdle;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  localparam int unsigned DEPTH   = 2048;
  localparam int unsigned LATENCY = 2;
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned WIN     = 64;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_req_valid = 1'b0;
  logic [31:0]   i_req_addr = 32'h0;
  logic          o_req_ready;
  logic          o_rsp_valid;
  logic [31:0]   o_rsp_data;
  logic          o_rsp_err;
  logic          i_rsp_ready = 1'b0;
  logic          i_flush = 1'b0;
  logic          i_ld_en = 1'b0;
  logic [AW-1:0] i_ld_addr = '0;
  logic [31:0]   i_ld_data = 32'h0;

  always #5 clk = ~clk;

  imem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .i_req_addr  (i_req_addr),
    .o_req_ready (o_req_ready),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_err   (o_rsp_err),
    .i_rsp_ready (i_rsp_ready),
    .i_flush     (i_flush),
    .i_ld_en     (i_ld_en),
    .i_ld_addr   (i_ld_addr),
    .i_ld_data   (i_ld_data)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: memory image plus one transaction in flight.
  logic [31:0] mem_m [DEPTH];
  bit          m_pend  = 1'b0;   // accepted, not yet delivered
  int          m_left  = 0;      // edges until delivery
  logic [31:0] m_pdata = 32'h0;
  logic        m_perr  = 1'b0;
  bit          m_valid = 1'b0;   // response on offer
  logic [31:0] m_data  = 32'h0;
  logic        m_err   = 1'b0;
  int          cyc     = 0;
  int          n_rsp   = 0;
  int          hs_cyc [$];

  function automatic bit model_ready();
    return !i_flush && !i_ld_en && ((!m_pend && !m_valid) || (m_valid && i_rsp_ready));
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: check ready before the edge, advance model, check outputs after.
  task automatic cycle();
    bit          rdy;
    bit          idle;
    logic [31:0] a;
    #1;
    rdy = model_ready();
    chk1("req_ready", o_req_ready, rdy);
    @(posedge clk);
    cyc++;
    if (i_rst) begin
      m_pend = 0; m_valid = 0; m_data = 32'h0; m_err = 1'b0; m_left = 0;
    end else if (i_flush) begin
      m_pend = 0; m_valid = 0;
    end else begin
      idle = !m_pend && !m_valid;
      if (i_ld_en && idle) mem_m[i_ld_addr] = i_ld_data;
      if (m_valid && i_rsp_ready) begin
        m_valid = 0;
        n_rsp++;
        hs_cyc.push_back(cyc);
      end
      if (m_pend) begin
        m_left--;
        if (m_left == 0) begin
          m_pend = 0; m_valid = 1; m_data = m_pdata; m_err = m_perr;
        end
      end
      if (i_req_valid && rdy) begin
        a = i_req_addr;
        if ((a % 4 != 0) || (a / 4 >= DEPTH)) begin
          m_pdata = 32'h0000_0013; m_perr = 1'b1;
        end else begin
          m_pdata = mem_m[a / 4]; m_perr = 1'b0;
        end
        m_left = LATENCY - 1;
        if (m_left == 0) begin
          m_valid = 1; m_data = m_pdata; m_err = m_perr;
        end else begin
          m_pend = 1;
        end
      end
    end
    #1;
    chk1("rsp_valid", o_rsp_valid, m_valid);
    if (m_valid) begin
      chk32("rsp_data", o_rsp_data, m_data);
      chk1("rsp_err", o_rsp_err, m_err);
    end
  endtask

  task automatic set_in(input bit v, input logic [31:0] a, input bit rr, input bit fl);
    i_req_valid = v;
    i_req_addr  = a;
    i_rsp_ready = rr;
    i_flush     = fl;
    i_ld_en     = 1'b0;
  endtask

  task automatic load(input int idx, input logic [31:0] d);
    set_in(0, 32'h0, 1, 0);
    i_ld_en   = 1'b1;
    i_ld_addr = AW'(idx);
    i_ld_data = d;
    cycle();
    i_ld_en   = 1'b0;
  endtask

  initial begin
    int idx;
    int n0;
    int r;
    bit acc;

    // Reset: state undefined before the first edge, so model checks start after.
    i_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_valid", o_rsp_valid, 1'b0);
    chk32("rst_data", o_rsp_data, 32'h0);
    chk1("rst_err", o_rsp_err, 1'b0);
    i_rst = 1'b0;
    #1;
    chk1("rst_ready", o_req_ready, 1'b1);

    // Preload program window.
    load(0, 32'h0010_0093);
    load(1, 32'h0020_0113);
    load(2, 32'h0030_0193);
    for (int i = 3; i < WIN; i++) load(i, $urandom);

    // Single request, latency check.
    set_in(1, 32'h0, 1, 0);
    cycle();
    set_in(0, 32'h0, 1, 0);
    chk1("lat_t1_valid", o_rsp_valid, 1'b0);
    cycle();
    chk1("lat_t2_valid", o_rsp_valid, 1'b1);
    chk32("lat_t2_data", o_rsp_data, 32'h0010_0093);
    repeat (2) cycle();

    // Back-to-back 0x0, 0x4, 0x8 with ready held high.
    n0 = n_rsp;
    hs_cyc.delete();
    idx = 0;
    for (int k = 0; k < 20; k++) begin
      set_in(idx < 3, 32'(idx * 4), 1, 0);
      acc = (idx < 3) && model_ready();
      cycle();
      if (acc) idx++;
    end
    chk_int("b2b_count", n_rsp - n0, 3);
    if (hs_cyc.size() >= 3) begin
      chk_int("b2b_gap1", hs_cyc[1] - hs_cyc[0], LATENCY);
      chk_int("b2b_gap2", hs_cyc[2] - hs_cyc[1], LATENCY);
    end

    // Backpressure for several cycles in RESP, then release.
    set_in(1, 32'hC, 0, 0);
    cycle();
    set_in(0, 32'h0, 0, 0);
    repeat (7) cycle();
    chk1("bp_ready_low", o_req_ready, 1'b0);
    set_in(0, 32'h0, 1, 0);
    repeat (2) cycle();

    // Error responses.
    set_in(1, 32'h2, 1, 0);
    cycle();
    set_in(0, 32'h0, 1, 0);
    repeat (3) cycle();
    set_in(1, 32'(4 * DEPTH), 1, 0);
    cycle();
    set_in(0, 32'h0, 1, 0);
    cycle();
    chk1("oob_err", o_rsp_err, 1'b1);
    chk32("oob_nop", o_rsp_data, 32'h0000_0013);
    repeat (2) cycle();

    // Flush one cycle after accept, then a normal request.
    set_in(1, 32'h8, 1, 0);
    cycle();
    set_in(0, 32'h0, 1, 1);
    cycle();
    set_in(0, 32'h0, 1, 0);
    repeat (4) cycle();
    set_in(1, 32'h4, 1, 0);
    cycle();
    set_in(0, 32'h0, 1, 0);
    repeat (3) cycle();

    // Load during WAIT is ignored.
    set_in(1, 32'h0, 1, 0);
    cycle();
    set_in(0, 32'h0, 1, 0);
    i_ld_en = 1'b1; i_ld_addr = '0; i_ld_data = 32'hDEAD_BEEF;
    cycle();
    i_ld_en = 1'b0;
    repeat (2) cycle();
    set_in(1, 32'h0, 1, 0);
    cycle();
    set_in(0, 32'h0, 1, 0);
    cycle();
    chk32("ld_ignored", o_rsp_data, 32'h0010_0093);
    repeat (2) cycle();

    // Reset while in RESP.
    set_in(1, 32'h4, 0, 0);
    cycle();
    set_in(0, 32'h0, 0, 0);
    repeat (2) cycle();
    i_rst = 1'b1;
    cycle();
    i_rst = 1'b0;
    chk1("rst_resp_valid", o_rsp_valid, 1'b0);
    chk32("rst_resp_data", o_rsp_data, 32'h0);
    repeat (2) cycle();

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 6)      i_req_addr = 32'($urandom_range(0, WIN - 1) * 4);
      else if (r == 7) i_req_addr = 32'($urandom_range(0, WIN - 1) * 4 + $urandom_range(1, 3));
      else if (r == 8) i_req_addr = 32'((DEPTH + $urandom_range(0, 1000)) * 4);
      else             i_req_addr = 32'h8000_0000 | ($urandom & 32'h7FFF_FFFC);
      i_req_valid = ($urandom_range(0, 9) < 6);
      i_rsp_ready = ($urandom_range(0, 9) < 7);
      i_flush     = ($urandom_range(0, 19) == 0);
      i_ld_en     = ($urandom_range(0, 19) == 0);
      i_ld_addr   = AW'($urandom_range(0, WIN - 1));
      i_ld_data   = $urandom;
      i_rst       = ($urandom_range(0, 99) == 0);
      cycle();
    end
    i_rst = 1'b0;
    set_in(0, 32'h0, 1, 0);
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder that serves fetch-stage read requests over a valid/ready request channel and a valid/ready response channel, returning one 32-bit instruction per request after a fixed, parameterised latency. It sits between the fetch stage and the instruction storage, replacing a zero-latency combinational lookup with a multi-cycle memory model. It also provides a branch-redirect flush and a word-wide load port for preloading programs.

## Interface
- DEPTH, 2048: memory size in 32-bit words; power of two.
- LATENCY, 2: cycles from request acceptance to response valid; legal range 1..15.
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_req_valid  input  1  fetch request present.
- i_req_addr  input  32  byte address of the instruction (PC).
- o_req_ready  output  1  request accepted this cycle when high with i_req_valid.
- o_rsp_valid  output  1  o_rsp_data/o_rsp_err valid.
- o_rsp_data  output  32  instruction word.
- o_rsp_err  output  1  request was misaligned or out of range.
- i_rsp_ready  input  1  consumer takes the response this cycle.
- i_flush  input  1  drop any outstanding request (branch redirect).
- i_ld_en  input  1  load-port write strobe.
- i_ld_addr  input  $clog2(DEPTH)  load word index.
- i_ld_data  input  32  load data.

## Operation
- States: IDLE, WAIT, RESP. Reset → IDLE.
- o_req_ready (combinational) = !i_flush && !i_ld_en && (IDLE || (RESP && i_rsp_ready)).
- Accept (i_req_valid && o_req_ready): latch address; counter ← LATENCY-1; go WAIT, or straight to RESP if LATENCY=1.
- WAIT: counter decrements each cycle; at counter=1 (expiring) go RESP and register response.
- Response register loaded on WAIT→RESP (or accept→RESP when LATENCY=1):
  - word index = addr[31:2]; if addr[1:0]!=0 or addr[31:2] >= DEPTH: o_rsp_data=32'h0000_0013 (NOP), o_rsp_err=1.
  - else o_rsp_data=mem[addr[31:2]], o_rsp_err=0.
- RESP: o_rsp_valid=1; data/err held stable until i_rsp_ready. On handshake: new accept same cycle → WAIT/RESP per above; else → IDLE.
- Flush: i_flush in WAIT or RESP → IDLE next cycle, o_rsp_valid=0 next cycle, no response ever issued for the dropped request. i_flush in IDLE: no request accepted that cycle. Flush beats a simultaneous response handshake: response counts as consumed, nothing new accepted.
- Load: i_ld_en honoured only in IDLE with !i_flush; mem[i_ld_addr] ← i_ld_data at the edge; no request accepted that cycle. i_ld_en outside IDLE ignored.
- Memory contents not affected by i_rst; uninitialised words read as X in simulation.

## Timing
- Reset values: state IDLE, o_rsp_valid=0, o_rsp_data=32'h0, o_rsp_err=0, counter=0; o_req_ready=1 in the first cycle after reset (given i_flush=0, i_ld_en=0).
- Request accepted at edge t → o_rsp_valid=1 from cycle t+LATENCY.
- Sustained throughput with i_rsp_ready held high: one response every LATENCY cycles (accept overlaps response handshake).
- Reset mid-operation (WAIT or RESP) → IDLE next edge, pending response discarded.
- Load written at edge t visible to a request accepted at edge t+1 or later.
- o_rsp_valid, o_rsp_data, o_rsp_err are registered; only o_req_ready is combinational.

## Test plan
- LATENCY=2, preload mem[0]=32'h0010_0093, request addr 0x0 at edge t, i_rsp_ready=1 → o_rsp_valid at t+2, data 32'h0010_0093, err 0.
- Back-to-back requests 0x0,0x4,0x8 with ready always high, mem[1]=32'h0020_0113, mem[2]=32'h0030_0193 → three responses in order, one every 2 cycles, o_req_ready high on each RESP handshake cycle.
- Response backpressure: i_rsp_ready=0 for 5 cycles in RESP → o_rsp_valid and data stable, o_req_ready=0; release → handshake, return to IDLE.
- Error: request 0x2 → 32'h0000_0013, err 1; request 4*DEPTH → 32'h0000_0013, err 1.
- Flush in WAIT one cycle after accept → no o_rsp_valid ever for that request; next request 0x4 served normally.
- Reset asserted in RESP → o_rsp_valid=0, o_rsp_data=0 next cycle; i_ld_en asserted during WAIT → memory unchanged, later read returns old value.
